frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Top-level capture sequencer for the pixel-array exposure/readout controller.
- Launches the controller with a one-cycle init pulse and supervises it through its busy status.
- Owns the exposure-time register, adjusted by the increase/decrease buttons.
- Delivers completed frames to the downstream consumer over a valid/ack handshake. Supports single-shot and continuous capture, abort, and start-timeout detection.

Parameters:
- EXP_MIN, 2, lowest exposure time (cycles).
- EXP_MAX, 30, highest exposure time (cycles).
- EXP_INIT, 5, exposure time after reset.
- GAP_CYCLES, 4, idle cycles between frames in continuous mode (min 1).
- START_TIMEOUT, 8, cycles allowed for rc_busy to rise after rc_init.
- FCNT_W, 8, frame counter width.
- DEB_CYCLES, 16, debounce stability count (used only with DEBOUNCE_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- increase  in  1  asynchronous button, exposure +1.
- decrease  in  1  asynchronous button, exposure -1.
- run  in  1  level, continuous capture enable.
- snap  in  1  synchronous one-cycle single-frame request.
- abort  in  1  synchronous one-cycle abort request.
- rc_busy  in  1  controller exposing or reading out.
- rc_init  out  1  one-cycle start pulse to controller.
- rc_reset  out  1  one-cycle abort pulse to controller.
- t_exp  out  5  exposure time applied to current frame.
- frame_valid  out  1  frame complete, awaiting ack.
- frame_ack  in  1  consumer accepts frame.
- frame_count  out  FCNT_W  accepted frames, wraps.
- error  out  1  sticky start-timeout flag.

Behaviour:
- Reset (reset=0, async): state IDLE. rc_init=0, rc_reset=0, frame_valid=0, frame_count=0, error=0. t_exp and t_exp_req = EXP_INIT. Sync/edge flops cleared. All outputs are registered.
- Buttons: 2-flop synchronizer, then rising-edge detect. t_exp_req changes on the 3rd clk edge after the button rises.
  - Increase: +1 if t_exp_req < EXP_MAX, else hold.
  - Decrease: -1 if t_exp_req > EXP_MIN, else hold.
  - Both edges in the same cycle: no change.
  - Edges are accepted in every state.
- t_exp is loaded from t_exp_req only in LAUNCH, so it is frozen for the whole frame.
- FSM:
  - IDLE: if abort, stay. Else if snap or run, go LAUNCH (snap has priority; both behave the same).
  - LAUNCH (1 cycle): rc_init=1, load t_exp, go ARM.
  - ARM: wait for rc_busy=1, then go CAPTURE.
    - If START_TIMEOUT cycles elapse (counted from the LAUNCH cycle) without rc_busy: error=1, rc_reset pulse, go IDLE.
    - abort: rc_reset pulse, go IDLE.
  - CAPTURE: wait for rc_busy=0, then go DELIVER with frame_valid=1.
    - abort: rc_reset pulse, go IDLE, no frame, frame_count unchanged.
  - DELIVER: hold frame_valid=1 until frame_ack=1 is sampled.
    - On ack: frame_valid=0 next cycle, frame_count+1 (wraps to 0 from all ones).
    - Then go GAP if run=1, else IDLE.
    - abort in DELIVER is ignored (frame is already captured).
  - GAP: count GAP_CYCLES, then go LAUNCH if run=1, else IDLE. abort goes IDLE.
- snap outside IDLE is dropped, not queued.
- frame_ack outside DELIVER is ignored.
- rc_init and rc_reset are never high in the same cycle.
- error clears only on reset and does not block further launches.
- Async reset mid-frame: all outputs return to reset values immediately. The controller is not sent rc_reset (it shares the reset).

Optional Feature:
- Macro DEBOUNCE_EN.
- Defined: after synchronization, each button level must be stable for DEB_CYCLES consecutive cycles before its filtered level changes. Edge detect runs on the filtered level, so one press gives exactly one step. Glitches shorter than DEB_CYCLES are ignored.
- Undefined: synchronizer plus edge detect only. DEB_CYCLES is unused.

Test Plan:
- Reset, pulse increase 30 times → t_exp_req saturates at 30. Pulse decrease 40 times → saturates at 2. Simultaneous increase+decrease edges → no change.
- snap in IDLE, model rc_busy high 2 cycles after rc_init for 20 cycles → rc_init one cycle, frame_valid rises after busy falls. Ack → frame_count=1, return to IDLE.
- run=1 with GAP_CYCLES=4, consumer acks after 3 cycles → back-to-back frames. rc_init spacing = ack-to-init gap of 4 cycles plus LAUNCH. frame_count increments per ack.
- snap, rc_busy held 0 → after 8 cycles rc_reset pulse, error=1, IDLE. A following snap with a good busy response completes a frame; error stays 1.
- abort during CAPTURE → rc_reset one cycle, IDLE, no frame_valid, frame_count unchanged. Exposure changed mid-frame → t_exp changes only at the next LAUNCH.
- DEBOUNCE_EN, DEB_CYCLES=16: 10-cycle glitch on increase → no change. 20-cycle press → exactly +1.

Source files
------------

// File: rtl/frame_scheduler_if.sv
// Controller and frame-delivery signals of the capture sequencer.
interface frame_scheduler_if #(
    parameter int unsigned FCNT_W = 8
);
    logic              rc_init;
    logic              rc_reset;
    logic              rc_busy;
    logic [4:0]        t_exp;
    logic              frame_valid;
    logic              frame_ack;
    logic [FCNT_W-1:0] frame_count;
    logic              error;

    modport master (
        output rc_init, rc_reset, t_exp, frame_valid, frame_count, error,
        input  rc_busy, frame_ack
    );

    modport slave (
        input  rc_init, rc_reset, t_exp, frame_valid, frame_count, error,
        output rc_busy, frame_ack
    );
endinterface

// File: rtl/frame_scheduler.sv
// Capture sequencer: launches the readout controller, owns exposure time, delivers frames.
// Optional DEBOUNCE_EN adds a DEB_CYCLES stability filter on the exposure buttons.
module frame_scheduler #(
    parameter int unsigned EXP_MIN       = 2,
    parameter int unsigned EXP_MAX       = 30,
    parameter int unsigned EXP_INIT      = 5,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned START_TIMEOUT = 8,
    parameter int unsigned FCNT_W        = 8
`ifdef DEBOUNCE_EN
    ,
    parameter int unsigned DEB_CYCLES    = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               increase,
    input  logic               decrease,
    input  logic               run,
    input  logic               snap,
    input  logic               abort,
    frame_scheduler_if.master  bus
);
    localparam int unsigned EXP_W = 5;
    localparam int unsigned TMR_W = $clog2(START_TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_ARM, S_CAPTURE, S_DELIVER, S_GAP
    } state_e;

    // Button conditioning: bit 0 = increase, bit 1 = decrease
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] prev_q, prev_d;
    logic [1:0] btn_lvl;
    logic [1:0] btn_rise;

    always_comb begin
        sync1_d = {decrease, increase};
        sync2_d = sync1_q;
        prev_d  = btn_lvl;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]            filt_q, filt_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // Filtered level follows the synchronized level only after DEB_CYCLES stable cycles
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn_lvl = filt_q;
`else
    assign btn_lvl = sync2_q;
`endif

    assign btn_rise = btn_lvl & ~prev_q;

    // Requested exposure; simultaneous edges cancel
    logic [EXP_W-1:0] t_exp_req_q, t_exp_req_d;

    always_comb begin
        t_exp_req_d = t_exp_req_q;
        if (btn_rise[0] && !btn_rise[1] && (t_exp_req_q < EXP_W'(EXP_MAX))) begin
            t_exp_req_d = t_exp_req_q + 1'b1;
        end else if (btn_rise[1] && !btn_rise[0] && (t_exp_req_q > EXP_W'(EXP_MIN))) begin
            t_exp_req_d = t_exp_req_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) t_exp_req_q <= EXP_W'(EXP_INIT);
        else        t_exp_req_q <= t_exp_req_d;
    end

    // Sequencer
    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              rc_init_q, rc_init_d;
    logic              rc_reset_q, rc_reset_d;
    logic [EXP_W-1:0]  t_exp_q, t_exp_d;
    logic              frame_valid_q, frame_valid_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;
    logic              error_q, error_d;
    logic              go_launch;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        gap_d         = gap_q;
        rc_init_d     = 1'b0;
        rc_reset_d    = 1'b0;
        t_exp_d       = t_exp_q;
        frame_valid_d = frame_valid_q;
        frame_count_d = frame_count_q;
        error_d       = error_q;
        go_launch     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!abort && (snap || run)) go_launch = 1'b1;
            end
            S_LAUNCH: begin
                state_d = S_ARM;
                tmr_d   = tmr_q + 1'b1;
            end
            S_ARM: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    rc_reset_d = 1'b1;
                end else if (bus.rc_busy) begin
                    state_d = S_CAPTURE;
                end else if (tmr_q == TMR_W'(START_TIMEOUT - 1)) begin
                    // Timer started in LAUNCH, so this is the last allowed cycle
                    state_d    = S_IDLE;
                    rc_reset_d = 1'b1;
                    error_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    rc_reset_d = 1'b1;
                end else if (!bus.rc_busy) begin
                    state_d       = S_DELIVER;
                    frame_valid_d = 1'b1;
                end
            end
            S_DELIVER: begin
                if (bus.frame_ack) begin
                    frame_valid_d = 1'b0;
                    frame_count_d = frame_count_q + 1'b1;
                    gap_d         = '0;
                    state_d       = run ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (run) go_launch = 1'b1;
                    else     state_d   = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Exposure is frozen at launch for the whole frame
        if (go_launch) begin
            state_d   = S_LAUNCH;
            rc_init_d = 1'b1;
            t_exp_d   = t_exp_req_q;
            tmr_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            gap_q         <= '0;
            rc_init_q     <= 1'b0;
            rc_reset_q    <= 1'b0;
            t_exp_q       <= EXP_W'(EXP_INIT);
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            gap_q         <= gap_d;
            rc_init_q     <= rc_init_d;
            rc_reset_q    <= rc_reset_d;
            t_exp_q       <= t_exp_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            error_q       <= error_d;
        end
    end

    assign bus.rc_init     = rc_init_q;
    assign bus.rc_reset    = rc_reset_q;
    assign bus.t_exp       = t_exp_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_frame_scheduler;
    localparam int unsigned FCNT_W   = 8;
    localparam int unsigned BUSY_LEN = 20;
`ifdef DEBOUNCE_EN
    localparam int HOLD = 20;
`else
    localparam int HOLD = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic increase = 1'b0, decrease = 1'b0, run = 1'b0, snap = 1'b0, abort = 1'b0;
    logic tb_busy = 1'b0, tb_ack = 1'b0, model_en = 1'b0;
    int   checks = 0, failures = 0;
    int   exp_cnt = 0;
    int unsigned mcnt;

    frame_scheduler_if #(.FCNT_W(FCNT_W)) bus();

    frame_scheduler #(
        .EXP_MIN(2), .EXP_MAX(30), .EXP_INIT(5), .GAP_CYCLES(4),
        .START_TIMEOUT(8), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .reset(reset), .increase(increase), .decrease(decrease),
        .run(run), .snap(snap), .abort(abort), .bus(bus)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises two cycles after rc_init, stays high BUSY_LEN cycles
    always @(posedge clk or negedge reset) begin
        if (!reset)                       mcnt <= 0;
        else if (bus.rc_reset)            mcnt <= 0;
        else if (model_en && bus.rc_init) mcnt <= 1;
        else if (mcnt == BUSY_LEN + 1)    mcnt <= 0;
        else if (mcnt != 0)               mcnt <= mcnt + 1;
    end

    assign bus.rc_busy   = model_en ? (mcnt >= 2) : tb_busy;
    assign bus.frame_ack = tb_ack;

    typedef struct {
        string              name;
        logic               snap, run, abort, busy, ack;
        logic               init, rrst, fv, err;
        logic [FCNT_W-1:0]  cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string n, input logic s, input logic r, input logic a,
                                input logic b, input logic k, input logic ei, input logic er,
                                input logic ef, input logic ee, input logic [FCNT_W-1:0] ec);
        vec_t v;
        v.name = n; v.snap = s; v.run = r; v.abort = a; v.busy = b; v.ack = k;
        v.init = ei; v.rrst = er; v.fv = ef; v.err = ee; v.cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.frame_valid;
            1:       return bus.rc_init;
            default: return bus.rc_reset;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, output int n, output logic found);
        n = 0;
        found = sig(which);
        while (!found && n < limit) begin
            step();
            n++;
            found = sig(which);
        end
    endtask

    task automatic press(input logic inc, input logic dec);
        increase = inc;
        decrease = dec;
        repeat (HOLD) step();
        increase = 1'b0;
        decrease = 1'b0;
        repeat (HOLD) step();
    endtask

    // Consumer accepts during the third valid cycle
    task automatic ack_frame(input string name);
        repeat (2) step();
        tb_ack = 1'b1;
        step();
        tb_ack = 1'b0;
        exp_cnt++;
        chk({name, "_fv_low"}, bus.frame_valid, 0);
        chk({name, "_count"}, bus.frame_count, exp_cnt[FCNT_W-1:0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int   n;
        logic found;

        // Reset values
        repeat (2) step();
        chk("rst_init", bus.rc_init, 0);
        chk("rst_rreset", bus.rc_reset, 0);
        chk("rst_fv", bus.frame_valid, 0);
        chk("rst_count", bus.frame_count, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_texp", bus.t_exp, 5);
        chk("rst_texp_req", dut.t_exp_req_q, 5);
        reset = 1'b1;
        step();

        // Single-shot, dropped snap, ignored abort/ack, aborts in CAPTURE and ARM
        //               name            snap run ab busy ack  init rrst fv err cnt
        vt.push_back(mk("idle_abort_snap", 1, 0, 1, 0, 0,   0, 0, 0, 0, 0));
        vt.push_back(mk("launch",          1, 0, 0, 0, 0,   1, 0, 0, 0, 0));
        vt.push_back(mk("arm_snap_drop",   1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vt.push_back(mk("arm_busy",        0, 0, 0, 1, 0,   0, 0, 0, 0, 0));
        vt.push_back(mk("cap_snap_drop",   1, 0, 0, 1, 0,   0, 0, 0, 0, 0));
        vt.push_back(mk("busy_fall",       0, 0, 0, 0, 0,   0, 0, 1, 0, 0));
        vt.push_back(mk("dlv_abort_ign",   0, 0, 1, 0, 0,   0, 0, 1, 0, 0));
        vt.push_back(mk("dlv_ack",         0, 0, 0, 0, 1,   0, 0, 0, 0, 1));
        vt.push_back(mk("idle_ack_ign",    0, 0, 0, 0, 1,   0, 0, 0, 0, 1));
        vt.push_back(mk("launch2",         1, 0, 0, 0, 0,   1, 0, 0, 0, 1));
        vt.push_back(mk("arm2",            0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
        vt.push_back(mk("arm_busy2",       0, 0, 0, 1, 0,   0, 0, 0, 0, 1));
        vt.push_back(mk("cap_abort",       0, 0, 1, 1, 0,   0, 1, 0, 0, 1));
        vt.push_back(mk("idle_post_abort", 0, 0, 0, 1, 0,   0, 0, 0, 0, 1));
        vt.push_back(mk("launch3",         1, 0, 0, 0, 0,   1, 0, 0, 0, 1));
        vt.push_back(mk("arm3",            0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
        vt.push_back(mk("arm_abort",       0, 0, 1, 0, 0,   0, 1, 0, 0, 1));
        vt.push_back(mk("idle_end",        0, 0, 0, 0, 0,   0, 0, 0, 0, 1));

        foreach (vt[i]) begin
            snap = vt[i].snap; run = vt[i].run; abort = vt[i].abort;
            tb_busy = vt[i].busy; tb_ack = vt[i].ack;
            step();
            chk({vt[i].name, "_init"}, bus.rc_init, vt[i].init);
            chk({vt[i].name, "_rreset"}, bus.rc_reset, vt[i].rrst);
            chk({vt[i].name, "_fv"}, bus.frame_valid, vt[i].fv);
            chk({vt[i].name, "_err"}, bus.error, vt[i].err);
            chk({vt[i].name, "_cnt"}, bus.frame_count, vt[i].cnt);
        end
        snap = 0; abort = 0; tb_busy = 0; tb_ack = 0;
        exp_cnt = 1;
        chk("texp_after_table", bus.t_exp, 5);

`ifndef DEBOUNCE_EN
        // Button edge reaches t_exp_req on the third clock edge
        increase = 1'b1;
        step(); chk("inc_edge1", dut.t_exp_req_q, 5);
        step(); chk("inc_edge2", dut.t_exp_req_q, 5);
        step(); chk("inc_edge3", dut.t_exp_req_q, 6);
        increase = 1'b0;
        repeat (3) step();
        chk("inc_single", dut.t_exp_req_q, 6);
`else
        press(1'b1, 1'b0);
        chk("inc_single", dut.t_exp_req_q, 6);
        // Short glitch is filtered out, long press gives one step
        increase = 1'b1; repeat (10) step(); increase = 1'b0; repeat (30) step();
        chk("deb_glitch", dut.t_exp_req_q, 6);
        increase = 1'b1; repeat (20) step(); increase = 1'b0; repeat (30) step();
        chk("deb_press", dut.t_exp_req_q, 7);
        press(1'b0, 1'b1);
        chk("deb_dec", dut.t_exp_req_q, 6);
`endif

        for (int i = 0; i < 30; i++) press(1'b1, 1'b0);
        chk("inc_saturate", dut.t_exp_req_q, 30);
        for (int i = 0; i < 40; i++) press(1'b0, 1'b1);
        chk("dec_saturate", dut.t_exp_req_q, 2);
        press(1'b1, 1'b0);
        chk("inc_from_min", dut.t_exp_req_q, 3);
        press(1'b1, 1'b1);
        chk("inc_dec_same", dut.t_exp_req_q, 3);

        // Exposure change mid-frame takes effect at the next launch
        model_en = 1'b1;
        snap = 1'b1; step(); snap = 1'b0;
        chk("mid_launch_init", bus.rc_init, 1);
        chk("mid_launch_texp", bus.t_exp, 3);
        repeat (4) step();
        press(1'b1, 1'b0);
        chk("mid_req_updated", dut.t_exp_req_q, 4);
        chk("mid_texp_frozen", bus.t_exp, 3);
        wait_for(0, 100, n, found);
        chk("mid_fv_seen", found, 1);
        ack_frame("mid");
        chk("mid_texp_after", bus.t_exp, 3);

        // Continuous capture with GAP_CYCLES between ack and next launch
        run = 1'b1;
        step();
        chk("run_launch_init", bus.rc_init, 1);
        chk("run_launch_texp", bus.t_exp, 4);
        for (int f = 0; f < 3; f++) begin
            wait_for(0, 100, n, found);
            chk("run_fv_seen", found, 1);
            if (f == 2) run = 1'b0;
            ack_frame("run");
            if (f < 2) begin
                wait_for(1, 20, n, found);
                chk("run_relaunch", found, 1);
                chk("run_gap", n, 4);
            end
        end
        wait_for(1, 10, n, found);
        chk("run_stop_idle", found, 0);

        // Start timeout: busy never rises
        model_en = 1'b0;
        tb_busy = 1'b0;
        snap = 1'b1; step(); snap = 1'b0;
        chk("to_init", bus.rc_init, 1);
        wait_for(2, 20, n, found);
        chk("to_rreset_seen", found, 1);
        chk("to_latency", n, 8);
        chk("to_error", bus.error, 1);
        chk("to_init_low", bus.rc_init, 0);
        step();
        chk("to_rreset_pulse", bus.rc_reset, 0);
        chk("to_error_sticky", bus.error, 1);

        // Launch after timeout still works, error stays set
        model_en = 1'b1;
        snap = 1'b1; step(); snap = 1'b0;
        chk("rec_init", bus.rc_init, 1);
        wait_for(0, 100, n, found);
        chk("rec_fv_seen", found, 1);
        ack_frame("rec");
        chk("rec_error", bus.error, 1);

        // Async reset in the middle of a frame
        snap = 1'b1; step(); snap = 1'b0;
        repeat (5) step();
        #2 reset = 1'b0;
        #1;
        chk("ar_fv", bus.frame_valid, 0);
        chk("ar_count", bus.frame_count, 0);
        chk("ar_error", bus.error, 0);
        chk("ar_texp", bus.t_exp, 5);
        chk("ar_texp_req", dut.t_exp_req_q, 5);
        chk("ar_init", bus.rc_init, 0);
        chk("ar_rreset", bus.rc_reset, 0);
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("ar_idle_fv", bus.frame_valid, 0);
        chk("ar_idle_init", bus.rc_init, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
